ps2_scan_decoder: RTL and testbench

//  Parametrised PS/2 keyboard receiver and scan-code decoder; supersedes the fixed arrow-key front end.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_scan_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types and constants for the PS/2 scan-code decoder.
// Rev    : 1.0  initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  function automatic logic [2:0] arrow_dir(input logic [7:0] code);
    case (code)
      SC_UP:    arrow_dir = DIR_UP;
      SC_DOWN:  arrow_dir = DIR_DOWN;
      SC_LEFT:  arrow_dir = DIR_LEFT;
      SC_RIGHT: arrow_dir = DIR_RIGHT;
      default:  arrow_dir = DIR_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module : ps2_line_filter
// Brief  : 2-flop synchroniser plus tick-gated run-length filter for one pin.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_filt
);

  logic [1:0]          r_sync;
  logic [FILT_LEN-1:0] r_hist;
  logic [FILT_LEN-1:0] w_hist_nxt;
  logic                r_filt;

  assign w_hist_nxt = {r_hist[FILT_LEN-2:0], r_sync[1]};
  assign o_filt     = r_filt;

  // The output only moves once the whole history agrees on the new level.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync <= 2'b11;
      r_hist <= '1;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) begin
        r_hist <= w_hist_nxt;
        if (&w_hist_nxt)
          r_filt <= 1'b1;
        else if (~|w_hist_nxt)
          r_filt <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : ps2_scan_decoder
// Brief  : PS/2 keyboard receiver, E0/F0 prefix tracker and arrow direction
//          holder. Optional auto-repeat of dir_pulse with `KB_REPEAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 200000
`ifdef KB_REPEAT_EN
  ,
  parameter int REPEAT_DLY  = 12500000,
  parameter int REPEAT_PER  = 2500000
`endif
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       frame_err,
  output logic [2:0] dir_out,
  output logic       dir_pulse
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic             w_c_filt;
  logic             w_d_filt;
  logic             r_c_prev;
  logic             w_fall;

  frame_state_t     r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic             r_par;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_frame_err;
  logic             w_timeout;
  logic             w_stop_ok;
  logic             w_byte_rdy;
  logic             w_err_now;

  logic             r_ext;
  logic             r_brk;
  logic             r_key_valid;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic             r_key_brk;
  logic [2:0]       r_dir;
  logic             r_dir_pulse;
  logic             w_key_evt;
  logic [2:0]       w_arrow;
  logic             w_make;
  logic             w_release;
  logic             w_rep_pulse;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (clr || w_tick)
      r_div <= '0;
    else
      r_div <= r_div + 1'b1;
  end

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_c (
    .clk(clk), .clr(clr), .i_tick(w_tick), .i_raw(PS2C), .o_filt(w_c_filt)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_d (
    .clk(clk), .clr(clr), .i_tick(w_tick), .i_raw(PS2D), .o_filt(w_d_filt)
  );

  always_ff @(posedge clk) begin
    if (clr) r_c_prev <= 1'b1;
    else     r_c_prev <= w_c_filt;
  end

  assign w_fall     = r_c_prev & ~w_c_filt;
  assign w_timeout  = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_stop_ok  = w_d_filt && (^{r_shreg, r_par});
  assign w_byte_rdy = w_fall && (r_state == STOP) && w_stop_ok;
  assign w_err_now  = w_timeout
                    | (w_fall && (r_state == IDLE) && w_d_filt)
                    | (w_fall && (r_state == STOP) && !w_stop_ok);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_shreg     <= 8'h00;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err_now;
      if (w_timeout) begin
        r_state  <= IDLE;
        r_to_cnt <= '0;
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          IDLE: begin
            if (!w_d_filt) begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            r_shreg   <= {w_d_filt, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_d_filt;
            r_state <= STOP;
          end
          STOP:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign w_key_evt = w_byte_rdy && (r_shreg != SC_EXT) && (r_shreg != SC_BRK);
  assign w_arrow   = arrow_dir(r_shreg);
  assign w_make    = w_key_evt && r_ext && !r_brk && (w_arrow != DIR_NONE);
  // Releasing an arrow other than the one currently held must not clear it.
  assign w_release = w_key_evt && r_ext && r_brk && (w_arrow != DIR_NONE) && (w_arrow == r_dir);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_brk   <= 1'b0;
      r_dir       <= DIR_NONE;
      r_dir_pulse <= 1'b0;
    end else begin
      r_key_valid <= w_key_evt;
      r_dir_pulse <= w_make | w_rep_pulse;
      if (w_key_evt) begin
        r_key_code <= r_shreg;
        r_key_ext  <= r_ext;
        r_key_brk  <= r_brk;
      end
      if (w_err_now || w_key_evt) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_rdy) begin
        if (r_shreg == SC_EXT) r_ext <= 1'b1;
        if (r_shreg == SC_BRK) r_brk <= 1'b1;
      end
      if (w_make)
        r_dir <= w_arrow;
      else if (w_release)
        r_dir <= DIR_NONE;
    end
  end

`ifdef KB_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;

  assign w_rep_pulse = (r_dir != DIR_NONE) &&
                       (r_rep_cnt == (r_rep_first ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_PER - 1)));

  always_ff @(posedge clk) begin
    if (clr || w_make || (r_dir == DIR_NONE)) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_pulse) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt   <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_pulse = 1'b0;
`endif

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_ext   = r_key_ext;
  assign key_break = r_key_brk;
  assign frame_err = r_frame_err;
  assign dir_out   = r_dir;
  assign dir_pulse = r_dir_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_scan_decoder
// Brief  : Directed PS/2 frames against an event-level model of the decoder.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

  localparam int CLK_DIV     = 4;
  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 3000;
  localparam int HALF        = 60;
`ifdef KB_REPEAT_EN
  localparam int REPEAT_DLY  = 1000;
  localparam int REPEAT_PER  = 400;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       frame_err;
  logic [2:0] dir_out;
  logic       dir_pulse;

  always #5 clk = ~clk;

  ps2_scan_decoder #(
    .CLK_DIV(CLK_DIV), .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
`ifdef KB_REPEAT_EN
    , .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
`endif
  ) dut (
    .clk(clk), .clr(clr), .PS2C(ps2c), .PS2D(ps2d),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .frame_err(frame_err), .dir_out(dir_out),
    .dir_pulse(dir_pulse)
  );

  typedef struct {
    bit         kv;
    bit         fe;
    bit         dp;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    logic [2:0] dir;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_kv = 0, n_fe = 0, n_dp = 0;
  logic [7:0] last_code = 8'h00;
  bit   last_ext = 0, last_brk = 0;
  logic [2:0] cur_dir = 3'd0;
  time  mk_t = 0;
  time  rep_t[$];

  // Model state: prefix flags and held direction as the keyboard user sees them.
  bit         m_ext = 0, m_brk = 0;
  logic [2:0] m_dir = 3'd0;

  function automatic logic [2:0] dir_of(input logic [7:0] b);
    case (b)
      8'h75:   return 3'd1;
      8'h72:   return 3'd2;
      8'h6B:   return 3'd3;
      8'h74:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic model_good(input logic [7:0] b);
    ev_t e;
    logic [2:0] d;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      d = dir_of(b);
      e.kv = 1; e.fe = 0; e.dp = 0;
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      if (m_ext && d != 3'd0) begin
        if (!m_brk) begin m_dir = d; e.dp = 1; end
        else if (d == m_dir) m_dir = 3'd0;
      end
      e.dir = m_dir;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_err();
    ev_t e;
    e.kv = 0; e.fe = 1; e.dp = 0; e.code = 8'h00; e.ext = 0; e.brk = 0; e.dir = m_dir;
    exp_q.push_back(e);
    m_ext = 0; m_brk = 0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2d = b;
    repeat (HALF / 2) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2d = 1'b1;
    repeat (200) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_good(b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  // Compare process: every strobe is matched against the next model event,
  // and dir_out is checked for hold between events.
  always @(posedge clk) begin
    ev_t e;
    bit  ok;
    #1;
    if (!clr) begin
      if (key_valid || frame_err || dir_pulse) begin
        if (key_valid) begin
          n_kv++; last_code = key_code; last_ext = key_ext; last_brk = key_break;
        end
        if (frame_err) n_fe++;
        if (dir_pulse) n_dp++;
`ifdef KB_REPEAT_EN
        if (dir_pulse && !key_valid && !frame_err) begin
          rep_t.push_back($time);
          n_cmp++;
          if (dir_out !== cur_dir || cur_dir == 3'd0) begin
            n_fail++;
            $display("FAIL repeat_dir: got dir=%0d, expected held dir=%0d", dir_out, cur_dir);
          end
        end else
`endif
        begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got kv=%0b fe=%0b dp=%0b code=%h, expected none",
                     key_valid, frame_err, dir_pulse, key_code);
          end else begin
            e  = exp_q.pop_front();
            ok = (key_valid == e.kv) && (frame_err == e.fe) && (dir_pulse == e.dp) && (dir_out == e.dir);
            if (e.kv) ok = ok && (key_code == e.code) && (key_ext == e.ext) && (key_break == e.brk);
            if (!ok) begin
              n_fail++;
              $display("FAIL strobe: got kv=%0b fe=%0b dp=%0b code=%h ext=%0b brk=%0b dir=%0d, expected kv=%0b fe=%0b dp=%0b code=%h ext=%0b brk=%0b dir=%0d",
                       key_valid, frame_err, dir_pulse, key_code, key_ext, key_break, dir_out,
                       e.kv, e.fe, e.dp, e.code, e.ext, e.brk, e.dir);
            end
            if (e.kv && e.dp) mk_t = $time;
            cur_dir = e.dir;
          end
        end
      end else begin
        n_cmp++;
        if (dir_out !== cur_dir) begin
          n_fail++;
          $display("FAIL dir_hold: got %0d, expected %0d", dir_out, cur_dir);
        end
      end
    end
  end

  initial begin
    int kv0, fe0, n;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {key_valid, key_code, key_ext, key_break, frame_err, dir_out, dir_pulse}, 32'd0);
    clr = 1'b0;
    repeat (50) @(negedge clk);

    // 1: plain make code
    send_byte(8'h1C);
    chk("t1_kv_count", n_kv, 1);
    chk("t1_code", last_code, 8'h1C);
    chk("t1_ext_brk", {last_ext, last_brk}, 2'b00);

    // 2: non-extended 75 is keypad, then arrow up make/break
    send_byte(8'h75);
    chk("t2_keypad_dir", dir_out, 3'd0);
    send_byte(8'hE0); send_byte(8'h75);
    chk("t2_up_dir", dir_out, 3'd1);
    chk("t2_up_pulses", n_dp, 1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("t2_brk_flag", {last_ext, last_brk}, 2'b11);
    chk("t2_release_dir", dir_out, 3'd0);

    // 3: parity, stop and start-bit errors; error clears a pending E0
    kv0 = n_kv; fe0 = n_fe;
    send_byte(8'hE0);
    model_err(); send_frame(8'h1C, 1'b1, 1'b0);
    chk("t3_parity_err", n_fe - fe0, 1);
    chk("t3_no_kv", n_kv - kv0, 0);
    send_byte(8'h1C);
    chk("t3_after_err_ext", last_ext, 1'b0);
    model_err(); send_frame(8'h1C, 1'b0, 1'b1);
    model_err(); ps2_bit(1'b1); repeat (200) @(negedge clk);
    chk("t3_err_total", n_fe - fe0, 3);

    // 4: two arrows held, latest wins
    send_byte(8'hE0); send_byte(8'h6B);
    chk("t4_left", dir_out, 3'd3);
    send_byte(8'hE0); send_byte(8'h74);
    chk("t4_right", dir_out, 3'd4);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    chk("t4_old_release", dir_out, 3'd4);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk("t4_release", dir_out, 3'd0);

    // 5a: timeout after start + 4 data bits, prefix cleared
    send_byte(8'hE0);
    model_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2d = 1'b1;
    n = 0;
    for (int i = 0; i < TIMEOUT_CYC + 500; i++) begin
      @(posedge clk); #1;
      if (frame_err) break;
      n++;
    end
    @(negedge clk);
    chk("t5_timeout_seen", frame_err | (n < TIMEOUT_CYC + 500), 1);
    chk("t5_timeout_window", (n >= TIMEOUT_CYC - HALF - 30 + 20) && (n <= TIMEOUT_CYC - HALF - 30 + 50), 1);
    repeat (200) @(negedge clk);
    send_byte(8'h1C);
    chk("t5_after_to_ext", last_ext, 1'b0);

    // 5b: clr mid-frame with a direction held and E0 pending
    send_byte(8'hE0); send_byte(8'h75);
    chk("t5_up_before_clr", dir_out, 3'd1);
    send_byte(8'hE0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    clr = 1'b1;
    m_ext = 0; m_brk = 0; m_dir = 3'd0;
    repeat (3) @(negedge clk);
    chk("t5_clr_outputs", {key_valid, key_code, key_ext, key_break, frame_err, dir_out, dir_pulse}, 32'd0);
    cur_dir = 3'd0;
    ps2d = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (200) @(negedge clk);
    send_byte(8'h1C);
    chk("t5_after_clr", {last_code, last_ext}, {8'h1C, 1'b0});

    // 6: 5-cycle glitch on PS2C must not clock a bit
    kv0 = n_kv; fe0 = n_fe;
    ps2c = 1'b0;
    repeat (5) @(negedge clk);
    ps2c = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_glitch", {n_kv - kv0, n_fe - fe0}, 64'd0);

`ifdef KB_REPEAT_EN
    rep_t.delete();
    send_byte(8'hE0); send_byte(8'h75);
    repeat (REPEAT_DLY + 2 * REPEAT_PER + 50) @(negedge clk);
    chk("rep_count_ge2", rep_t.size() >= 2, 1);
    if (rep_t.size() >= 2) begin
      chk("rep_first_dly", rep_t[0] - mk_t, REPEAT_DLY * 10);
      chk("rep_period", rep_t[1] - rep_t[0], REPEAT_PER * 10);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
`endif

    repeat (300) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
